// File: rtl/rst_seq_pkg.sv
// Shared types for the staged reset sequencer.
// State encoding and reset-cause codes.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

endpackage

// File: rtl/rst_sequencer_sync_2ff.sv
// Generic two-flop synchroniser with synchronous
// active-high reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds all stages in reset,
// then releases them in ascending order and flags ready.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    input  logic                  ext_rst_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [1:0]            rst_cause
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ?
                             HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int IW = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_gap;
    logic [IW-1:0]         r_idx;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_ready;
    logic [1:0]            r_cause;

    logic w_ext_s;
    logic w_req;

    sync_2ff #(
        .W (1)
    ) u_ext_sync (
        .clk (clk),
        .rst (rst),
        .i_d (ext_rst_req),
        .o_q (w_ext_s)
    );

    assign w_req = w_ext_s | sw_rst_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_cause   <= CAUSE_POR;
        end else if (w_req) begin
            // Any request restarts the hold window from zero.
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_cause   <= w_ext_s ? CAUSE_EXT : CAUSE_SW;
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    r_rst_out <= '1;
                    r_ready   <= 1'b0;
                    if (r_cnt == HOLD_LAST) begin
                        r_rst_out <= ~ONE;
                        r_idx     <= IW'(1);
                        r_gap     <= '0;
                        r_state   <= (NUM_STAGES == 1) ?
                                     ST_RUN : ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_gap == GAP_LAST) begin
                        r_rst_out <= r_rst_out & ~(ONE << r_idx);
                        r_gap     <= '0;
                        r_idx     <= r_idx + IW'(1);
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_gap <= r_gap + CW'(1);
                    end
                end
                ST_RUN: begin
                    r_rst_out <= '0;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign rst_cause = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with
// HOLD_CYCLES=4, GAP_CYCLES=2, NUM_STAGES=3.
module tb_rst_sequencer;

    logic       clk;
    logic       rst;
    logic       sw_rst_req;
    logic       ext_rst_req;
    logic [2:0] rst_out;
    logic       ready;
    logic [1:0] rst_cause;

    int n_checks;
    int n_fail;

    rst_sequencer #(
        .NUM_STAGES  (3),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .ext_rst_req (ext_rst_req),
        .rst_out     (rst_out),
        .ready       (ready),
        .rst_cause   (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {rst_out, ready} n edges after the last request edge.
    function automatic logic [3:0] seq_exp(input int n);
        case (n)
            0, 1, 2, 3: seq_exp = 4'b1110;
            4, 5:       seq_exp = 4'b1100;
            6, 7:       seq_exp = 4'b1000;
            8:          seq_exp = 4'b0000;
            default:    seq_exp = 4'b0001;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({rst_out, ready, rst_cause} !== 6'b111000) begin
            n_fail++;
            $display("FAIL por_reset got=%b want=%b",
                     {rst_out, ready, rst_cause}, 6'b111000);
        end
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            n_checks++;
            if ({rst_out, ready, rst_cause} !== {seq_exp(n), 2'b00}) begin
                n_fail++;
                $display("FAIL por_seq n=%0d got=%b want=%b", n,
                         {rst_out, ready, rst_cause}, {seq_exp(n), 2'b00});
            end
        end
    endtask

    task automatic test_sw_pulse();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int n = 0; n <= 9; n++) begin
            if (n > 0) tick();
            n_checks++;
            if ({rst_out, ready, rst_cause} !== {seq_exp(n), 2'b10}) begin
                n_fail++;
                $display("FAIL sw_seq n=%0d got=%b want=%b", n,
                         {rst_out, ready, rst_cause}, {seq_exp(n), 2'b10});
            end
        end
    endtask

    task automatic test_ext_level();
        logic [5:0] exp;
        ext_rst_req = 1'b1;
        for (int j = 0; j <= 30; j++) begin
            tick();
            if (j == 19) ext_rst_req = 1'b0;
            if (j < 2)       exp = 6'b000110;
            else if (j <= 21) exp = 6'b111001;
            else             exp = {seq_exp(j - 21), 2'b01};
            n_checks++;
            if ({rst_out, ready, rst_cause} !== exp) begin
                n_fail++;
                $display("FAIL ext_level j=%0d got=%b want=%b", j,
                         {rst_out, ready, rst_cause}, exp);
            end
        end
    endtask

    task automatic test_mid_release();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        n_checks++;
        if ({rst_out, ready, rst_cause} !== 6'b100000) begin
            n_fail++;
            $display("FAIL mid_pre got=%b want=%b",
                     {rst_out, ready, rst_cause}, 6'b100000);
        end
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int n = 0; n <= 9; n++) begin
            if (n > 0) tick();
            n_checks++;
            if ({rst_out, ready, rst_cause} !== {seq_exp(n), 2'b10}) begin
                n_fail++;
                $display("FAIL mid_seq n=%0d got=%b want=%b", n,
                         {rst_out, ready, rst_cause}, {seq_exp(n), 2'b10});
            end
        end
    endtask

    task automatic test_simultaneous();
        ext_rst_req = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({rst_out, ready, rst_cause} !== 6'b000110) begin
            n_fail++;
            $display("FAIL simul_sync got=%b want=%b",
                     {rst_out, ready, rst_cause}, 6'b000110);
        end
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req  = 1'b0;
        ext_rst_req = 1'b0;
        n_checks++;
        if ({rst_out, ready, rst_cause} !== 6'b111001) begin
            n_fail++;
            $display("FAIL simul_cause got=%b want=%b",
                     {rst_out, ready, rst_cause}, 6'b111001);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 50 && ready !== 1'b1; i++) tick();
        n_checks++;
        if (ready !== 1'b1 || rst_out !== 3'b000) begin
            n_fail++;
            $display("FAIL %s_timeout ready=%b rst_out=%b want 1/000",
                     tag, ready, rst_out);
        end
    endtask

    task automatic test_rst_in_run();
        wait_ready("pre_sw");
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        wait_ready("post_sw");
        n_checks++;
        if (rst_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL run_cause got=%b want=10", rst_cause);
        end
        rst        = 1'b1;
        sw_rst_req = 1'b1;
        tick();
        rst        = 1'b0;
        sw_rst_req = 1'b0;
        n_checks++;
        if ({rst_out, ready, rst_cause} !== 6'b111000) begin
            n_fail++;
            $display("FAIL rst_run got=%b want=%b",
                     {rst_out, ready, rst_cause}, 6'b111000);
        end
        tick();
        n_checks++;
        if ({rst_out, ready, rst_cause} !== 6'b111000) begin
            n_fail++;
            $display("FAIL rst_run_next got=%b want=%b",
                     {rst_out, ready, rst_cause}, 6'b111000);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        sw_rst_req  = 1'b0;
        ext_rst_req = 1'b0;
        test_reset();
        test_sw_pulse();
        test_ext_level();
        test_mid_release();
        test_simultaneous();
        test_rst_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Generates staged, active-high synchronous reset outputs for downstream flip-flop banks.
- Drives the reset side of the flip-flop interface rather than consuming it.
- Merges power-on reset, a software reset pulse and an external asynchronous reset request into one sequence.
- Holds all stages in reset for a fixed time, then releases them one by one in order and signals ready.

Parameters:
- NUM_STAGES, 3, number of reset output stages (legal range 1..8)
- HOLD_CYCLES, 16, cycles that all outputs stay asserted after the last active request (>=1)
- GAP_CYCLES, 4, cycles between consecutive stage releases (>=1)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high block reset; acts as the power-on request
- sw_rst_req  input  1  single-cycle software reset request, synchronous to clk
- ext_rst_req  input  1  asynchronous level request, active-high; synchronised internally
- rst_out  output  NUM_STAGES  per-stage active-high reset; bit 0 releases first
- ready  output  1  high when every stage is released and the sequencer is in RUN
- rst_cause  output  2  cause of the last sequence: 00 POR, 01 EXT, 10 SW, 11 reserved

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values (rst high at an edge):
  - rst_out = all ones; ready = 0; rst_cause = 00
  - state = HOLD; hold counter = 0
  - synchroniser flops cleared to 0
- ext_rst_req passes through a 2-flop synchroniser to give ext_s. ext_rst_req high before edge k gives ext_s high after edge k+1.
- req = ext_s | sw_rst_req.
- States: HOLD, RELEASE, RUN.
- HOLD:
  - rst_out all ones.
  - If req is set, the counter clears to 0 and the state stays HOLD. A held-high ext_s therefore keeps HOLD indefinitely.
  - Otherwise the counter increments. At the edge where the counter equals HOLD_CYCLES-1: rst_out[0] clears, the stage index is set to 1, the gap counter clears, and the state becomes RELEASE.
- RELEASE:
  - The gap counter counts edges. Every GAP_CYCLES edges, rst_out[stage index] clears and the stage index increments.
  - At the edge that clears the last stage, or immediately when NUM_STAGES=1, the state becomes RUN.
  - ready rises one edge after the state enters RUN.
- RUN: rst_out all zeros; ready = 1.
- Request during RELEASE or RUN: at the edge where req is sampled, rst_out becomes all ones, ready clears, the counter clears, and the state becomes HOLD.
- Cause capture:
  - rst_cause updates at every edge where req is sampled in any state.
  - Priority: ext_s over sw_rst_req. Both high at once gives 01.
  - rst high always forces 00.
- Latency:
  - sw_rst_req to rst_out asserted: 1 edge.
  - ext_rst_req to rst_out asserted: 3 edges (2 synchroniser flops + 1).
- Release timing, with e0 as the last edge sampling rst=1 or req=1:
  - rst_out[i] clears at e0 + HOLD_CYCLES + i*GAP_CYCLES.
  - ready rises at e0 + HOLD_CYCLES + (NUM_STAGES-1)*GAP_CYCLES + 1.
- Monotonic outputs: rst_out bits only clear in ascending index order and only set all together.
- Widths: hold and gap counters are $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits; the stage index is $clog2(NUM_STAGES+1) bits. No counter wraps, because every comparison ends the phase before overflow.
- rst mid-operation always wins over req and restarts the sequence from HOLD with cause 00.
- No outputs are combinational from inputs; all are registered.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum (HOLD, RELEASE, RUN)
  - cause codes as localparams: CAUSE_POR=2'b00, CAUSE_EXT=2'b01, CAUSE_SW=2'b10
- One sub-module, sync_2ff: a generic 2-flop synchroniser with synchronous active-high reset, used for ext_rst_req.

Test Plan (all with HOLD_CYCLES=4, GAP_CYCLES=2, NUM_STAGES=3):
- POR: rst high for 3 edges, last at e0 -> rst_out[0] clears at e4, rst_out[1] at e6, rst_out[2] at e8; ready=1 at e9; rst_cause=00 throughout.
- Software pulse in RUN: sw_rst_req high for one cycle sampled at edge k -> rst_out=3'b111 and ready=0 after k; rst_cause=10; rst_out[0] clears at k+4; ready at k+9.
- External held level: ext_rst_req high for 20 cycles -> rst_out stays 3'b111 for the whole window and 4 edges after ext_s falls; rst_cause=01.
- Request mid-release: sw_rst_req at e7 (rst_out=3'b100) -> rst_out=3'b111 after e7; a full sequence follows with rst_out[0] clearing at e11.
- Simultaneous requests: ext_s and sw_rst_req both high at the same edge -> rst_cause=01.
- rst during RUN with rst_cause=10 -> rst_out=3'b111, rst_cause=00, ready=0 next edge.
